// File: rtl/debounce_multi_if.sv
// Interface bundling the raw inputs and the filtered outputs of debounce_multi.
// The master side (board / testbench) drives pin and observes the filtered
// pout level and the one-cycle rise/fall strobes; the slave side is the debouncer.
interface debounce_multi_if #(
  parameter int CH = 4
);
  logic [CH-1:0] pin;
  logic [CH-1:0] pout;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  modport master (output pin, input pout, input rise, input fall);
  modport slave  (input pin, output pout, output rise, output fall);
endinterface

// File: rtl/debounce_multi.sv
// debounce_multi: CH independent debounce channels with rise/fall strobes.
// Each raw pin goes through an input register stage. Its filtered level pout
// changes only after the stage output s has disagreed with pout for 2^N
// consecutive samples. Any agreeing sample restarts the count.
// Optional build macro DEBOUNCE_SYNC_EN: when defined, a two-flop synchroniser
// is used per channel (L=2). Otherwise a single input register is used (L=1).
// FAST_RELEASE=1 lets a falling level through after the input stage only.
// The interface has no handshake. pin is sampled every cycle, and every output
// comes straight from a flop.
module debounce_multi #(
  parameter int CH           = 4,
  parameter int N            = 4,
  parameter int FAST_RELEASE = 0
) (
  input logic            clk,
  input logic            rst,
  debounce_multi_if.slave bus
);

`ifdef DEBOUNCE_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic [L-1:0][CH-1:0] sync_q;
  logic [CH-1:0]        s;
  logic [CH-1:0][N-1:0] cnt, cnt_d;
  logic [CH-1:0]        pout, pout_d;
  logic [CH-1:0]        rise, rise_d;
  logic [CH-1:0]        fall, fall_d;

  // Input stage: shift raw pins through L registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.pin;
      for (int k = 1; k < L; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[L-1];

  // Per-channel filter decision, in priority order. The counter saturates
  // into acceptance, so it never wraps.
  always_comb begin
    cnt_d  = cnt;
    pout_d = pout;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CH; i++) begin
      if ((FAST_RELEASE != 0) && !s[i] && pout[i]) begin
        pout_d[i] = 1'b0;
        fall_d[i] = 1'b1;
        cnt_d[i]  = '0;
      end else if (s[i] == pout[i]) begin
        cnt_d[i] = '0;
      end else if (&cnt[i]) begin
        pout_d[i] = s[i];
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt[i] + N'(1);
      end
    end
  end

  // Filter state and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      pout <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      cnt  <= cnt_d;
      pout <= pout_d;
      rise <= rise_d;
      fall <= fall_d;
    end
  end

  assign bus.pout = pout;
  assign bus.rise = rise;
  assign bus.fall = fall;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi. Two instances see the same pins: dut0
// filters both edges, and dut1 uses FAST_RELEASE=1. Expected values come from
// the documented latencies: edge 2^N+L for filtered changes and edge L+1 for
// fast release.
module tb_debounce_multi;

`ifdef DEBOUNCE_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int N = 4;
  localparam int F = (2 ** N) + L;

  logic       clk;
  logic       rst;
  logic [3:0] pin_v;
  int         vectors;
  int         errors;

  debounce_multi_if #(.CH(4)) bus0 ();
  debounce_multi_if #(.CH(4)) bus1 ();

  assign bus0.pin = pin_v;
  assign bus1.pin = pin_v;

  debounce_multi #(.CH(4), .N(N), .FAST_RELEASE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  debounce_multi #(.CH(4), .N(N), .FAST_RELEASE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [3:0] p0, input logic [3:0] r0, input logic [3:0] f0,
                           input logic [3:0] p1, input logic [3:0] r1, input logic [3:0] f1);
    check({tag, " dut0.pout"}, bus0.pout, p0);
    check({tag, " dut0.rise"}, bus0.rise, r0);
    check({tag, " dut0.fall"}, bus0.fall, f0);
    check({tag, " dut1.pout"}, bus1.pout, p1);
    check({tag, " dut1.rise"}, bus1.rise, r1);
    check({tag, " dut1.fall"}, bus1.fall, f1);
  endtask

  // Advance one clock and move to a point just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply a new stable pin level. Both instances start settled at 'from'.
  // Every edge up to F+1 is then checked.
  task automatic edge_seq(input string tag, input logic [3:0] from, input logic [3:0] to);
    logic [3:0] rb, fb, p1;
    rb = to & ~from;
    fb = from & ~to;
    pin_v = to;
    for (int e = 1; e <= F + 1; e++) begin
      step();
      p1 = from;
      if (e >= L + 1) p1 = p1 & ~fb;
      if (e >= F)     p1 = p1 | rb;
      check_all($sformatf("%s e%0d", tag, e),
                (e < F) ? from : to, (e == F) ? rb : 4'h0, (e == F) ? fb : 4'h0,
                p1,                  (e == F) ? rb : 4'h0, (e == L + 1) ? fb : 4'h0);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    pin_v   = 4'hF;

    // Reset held with all pins high: every output stays low.
    for (int e = 1; e <= 2; e++) begin
      step();
      check_all($sformatf("in_reset e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst = 1'b0;
    edge_seq("reset_release", 4'h0, 4'hF);

    // Falling channel 1 is filtered on dut0 and released quickly on dut1.
    edge_seq("fall_ch1", 4'hF, 4'hD);
    edge_seq("fall_ch2", 4'hD, 4'h9);
    edge_seq("clear", 4'h9, 4'h0);

    // Single-channel rise, then drop it again.
    edge_seq("rise_ch0", 4'h0, 4'h1);
    edge_seq("drop_ch0", 4'h1, 4'h0);

    // Glitch: 15 high samples, 1 low sample, then high. The glitch is rejected.
    pin_v = 4'h1;
    for (int e = 1; e <= 15; e++) begin
      step();
      check_all($sformatf("glitch_hi e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    pin_v = 4'h0;
    step();
    check_all("glitch_lo", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    edge_seq("glitch_recover", 4'h0, 4'h1);
    edge_seq("glitch_drop", 4'h1, 4'h0);

    // A 16-cycle pulse is just long enough to be accepted.
    pin_v = 4'h1;
    for (int e = 1; e <= F + 1; e++) begin
      if (e == 17) pin_v = 4'h0;
      step();
      check_all($sformatf("pulse16 e%0d", e),
                (e < F) ? 4'h0 : 4'h1, (e == F) ? 4'h1 : 4'h0, 4'h0,
                (e == F) ? 4'h1 : 4'h0, (e == F) ? 4'h1 : 4'h0, (e == F + 1) ? 4'h1 : 4'h0);
    end
    for (int e = 1; e <= F + 2; e++) step();
    check_all("pulse16 settled", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    // Asynchronous reset while channel 0 is at cnt=9 and channel 3 is high.
    edge_seq("set_ch3", 4'h0, 4'h8);
    pin_v = 4'h9;
    for (int e = 1; e <= L + 9; e++) begin
      step();
      check_all($sformatf("midcount e%0d", e), 4'h8, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0);
    end
    #3;
    rst = 1'b1;
    #1;
    check_all("async_clear", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step();
    check_all("reset_edge", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    edge_seq("post_reset", 4'h0, 4'h9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
